// File: rtl/ps2_hack_keymap.sv
// Maps MiSTer ps2_key events to the Hack keyboard code; HACK_KEY_SHIFT_EN adds shifted symbols.
// Latency 2 clocks from toggle to hack_scancode; no backpressure, accepts one event per cycle.
module ps2_hack_keymap #(
  parameter int unsigned STUCK_TIMEOUT = 0,
  parameter int unsigned TIMER_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic [7:0]  hack_scancode,
  output logic        key_event
);

  localparam logic [TIMER_W-1:0] TO_LIM = TIMER_W'(STUCK_TIMEOUT);

  // Returns {mapped, hack_code}; shift only affects digits and punctuation.
  function automatic logic [8:0] key_lookup(input logic ext, input logic [7:0] code,
                                            input logic shift);
    logic [8:0] r;
    r = '0;
    if (ext) begin
      case (code)
        8'h6B:   r = {1'b1, 8'd130};
        8'h75:   r = {1'b1, 8'd131};
        8'h74:   r = {1'b1, 8'd132};
        8'h72:   r = {1'b1, 8'd133};
        8'h6C:   r = {1'b1, 8'd134};
        8'h69:   r = {1'b1, 8'd135};
        8'h7D:   r = {1'b1, 8'd136};
        8'h7A:   r = {1'b1, 8'd137};
        8'h70:   r = {1'b1, 8'd138};
        8'h71:   r = {1'b1, 8'd139};
        default: r = '0;
      endcase
    end else begin
      case (code)
        8'h1C:   r = {1'b1, 8'd65};
        8'h32:   r = {1'b1, 8'd66};
        8'h21:   r = {1'b1, 8'd67};
        8'h23:   r = {1'b1, 8'd68};
        8'h24:   r = {1'b1, 8'd69};
        8'h2B:   r = {1'b1, 8'd70};
        8'h34:   r = {1'b1, 8'd71};
        8'h33:   r = {1'b1, 8'd72};
        8'h43:   r = {1'b1, 8'd73};
        8'h3B:   r = {1'b1, 8'd74};
        8'h42:   r = {1'b1, 8'd75};
        8'h4B:   r = {1'b1, 8'd76};
        8'h3A:   r = {1'b1, 8'd77};
        8'h31:   r = {1'b1, 8'd78};
        8'h44:   r = {1'b1, 8'd79};
        8'h4D:   r = {1'b1, 8'd80};
        8'h15:   r = {1'b1, 8'd81};
        8'h2D:   r = {1'b1, 8'd82};
        8'h1B:   r = {1'b1, 8'd83};
        8'h2C:   r = {1'b1, 8'd84};
        8'h3C:   r = {1'b1, 8'd85};
        8'h2A:   r = {1'b1, 8'd86};
        8'h1D:   r = {1'b1, 8'd87};
        8'h22:   r = {1'b1, 8'd88};
        8'h35:   r = {1'b1, 8'd89};
        8'h1A:   r = {1'b1, 8'd90};
        8'h45:   r = {1'b1, shift ? 8'd41  : 8'd48};
        8'h16:   r = {1'b1, shift ? 8'd33  : 8'd49};
        8'h1E:   r = {1'b1, shift ? 8'd64  : 8'd50};
        8'h26:   r = {1'b1, shift ? 8'd35  : 8'd51};
        8'h25:   r = {1'b1, shift ? 8'd36  : 8'd52};
        8'h2E:   r = {1'b1, shift ? 8'd37  : 8'd53};
        8'h36:   r = {1'b1, shift ? 8'd94  : 8'd54};
        8'h3D:   r = {1'b1, shift ? 8'd38  : 8'd55};
        8'h3E:   r = {1'b1, shift ? 8'd42  : 8'd56};
        8'h46:   r = {1'b1, shift ? 8'd40  : 8'd57};
        8'h29:   r = {1'b1, 8'd32};
        8'h4E:   r = {1'b1, shift ? 8'd95  : 8'd45};
        8'h55:   r = {1'b1, shift ? 8'd43  : 8'd61};
        8'h54:   r = {1'b1, shift ? 8'd123 : 8'd91};
        8'h5B:   r = {1'b1, shift ? 8'd125 : 8'd93};
        8'h5D:   r = {1'b1, shift ? 8'd124 : 8'd92};
        8'h4C:   r = {1'b1, shift ? 8'd58  : 8'd59};
        8'h52:   r = {1'b1, shift ? 8'd34  : 8'd39};
        8'h41:   r = {1'b1, shift ? 8'd60  : 8'd44};
        8'h49:   r = {1'b1, shift ? 8'd62  : 8'd46};
        8'h4A:   r = {1'b1, shift ? 8'd63  : 8'd47};
        8'h0E:   r = {1'b1, shift ? 8'd126 : 8'd96};
        8'h5A:   r = {1'b1, 8'd128};
        8'h66:   r = {1'b1, 8'd129};
        8'h76:   r = {1'b1, 8'd140};
        8'h05:   r = {1'b1, 8'd141};
        8'h06:   r = {1'b1, 8'd142};
        8'h04:   r = {1'b1, 8'd143};
        8'h0C:   r = {1'b1, 8'd144};
        8'h03:   r = {1'b1, 8'd145};
        8'h0B:   r = {1'b1, 8'd146};
        8'h83:   r = {1'b1, 8'd147};
        8'h0A:   r = {1'b1, 8'd148};
        8'h01:   r = {1'b1, 8'd149};
        8'h09:   r = {1'b1, 8'd150};
        8'h78:   r = {1'b1, 8'd151};
        8'h07:   r = {1'b1, 8'd152};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  logic       armed;
  logic       prev_toggle;
  logic       ev0;
  logic       shift_act;
  logic [8:0] lk;

  logic       s1_vld;
  logic       s1_pressed;
  logic [8:0] s1_key;
  logic       s1_mapped;
  logic [7:0] s1_hack;

  logic       held_vld;
  logic [8:0] held_key;
  logic       expire;

  // The first post-reset clock only samples the toggle, so an idle-high strobe is not an event.
  assign ev0 = armed && (ps2_key[10] != prev_toggle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed       <= 1'b0;
      prev_toggle <= 1'b0;
    end else begin
      armed       <= 1'b1;
      prev_toggle <= ps2_key[10];
    end
  end

`ifdef HACK_KEY_SHIFT_EN
  logic lshift_q;
  logic rshift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
    end else if (ev0 && !ps2_key[8]) begin
      if (ps2_key[7:0] == 8'h12) lshift_q <= ps2_key[9];
      if (ps2_key[7:0] == 8'h59) rshift_q <= ps2_key[9];
    end
  end

  assign shift_act = lshift_q | rshift_q;
`else
  assign shift_act = 1'b0;
`endif

  assign lk = key_lookup(ps2_key[8], ps2_key[7:0], shift_act);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld     <= 1'b0;
      s1_pressed <= 1'b0;
      s1_key     <= '0;
      s1_mapped  <= 1'b0;
      s1_hack    <= '0;
    end else begin
      s1_vld <= ev0;
      if (ev0) begin
        s1_pressed <= ps2_key[9];
        s1_key     <= ps2_key[8:0];
        s1_mapped  <= lk[8];
        s1_hack    <= lk[7:0];
      end
    end
  end

  // Counter holds cycles since the event cycle inclusive, so expiry lands STUCK_TIMEOUT cycles after it.
  generate
    if (STUCK_TIMEOUT != 0) begin : g_timeout
      logic [TIMER_W-1:0] cnt_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else if (ev0) begin
          cnt_q <= TIMER_W'(1);
        end else if ((held_vld || s1_vld) && (cnt_q != TO_LIM)) begin
          cnt_q <= cnt_q + TIMER_W'(1);
        end
      end

      assign expire = held_vld && !ev0 && !s1_vld && (cnt_q >= TO_LIM - TIMER_W'(1));
    end else begin : g_no_timeout
      assign expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_vld      <= 1'b0;
      held_key      <= '0;
      hack_scancode <= '0;
      key_event     <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (s1_vld) begin
        if (s1_pressed && s1_mapped) begin
          held_vld      <= 1'b1;
          held_key      <= s1_key;
          hack_scancode <= s1_hack;
          key_event     <= (s1_hack != hack_scancode);
        end else if (!s1_pressed && held_vld && (s1_key == held_key)) begin
          held_vld      <= 1'b0;
          hack_scancode <= '0;
          key_event     <= (hack_scancode != 8'd0);
        end
      end else if (expire) begin
        held_vld      <= 1'b0;
        hack_scancode <= '0;
        key_event     <= (hack_scancode != 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_ps2_hack_keymap.sv
// Scoreboarded bench for ps2_hack_keymap with a 100-cycle stuck-key timeout.
module tb_ps2_hack_keymap;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [7:0]  hack_scancode;
  logic        key_event;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ev = 0;
  int exp_cyc[$];
  int exp_val[$];
  logic       mon_en = 1'b0;
  logic [7:0] last_seen = 8'd0;

`ifdef HACK_KEY_SHIFT_EN
  localparam int SHIFT_ONE = 33;
`else
  localparam int SHIFT_ONE = 49;
`endif

  // {ext, code} and the hand-computed Hack value for press/release pairs
  logic [8:0] tk [9] = '{9'h01A, 9'h076, 9'h083, 9'h171, 9'h045, 9'h00E, 9'h005, 9'h17A, 9'h04A};
  int         tv [9] = '{90, 140, 147, 139, 48, 96, 141, 137, 47};

  ps2_hack_keymap #(.STUCK_TIMEOUT(100), .TIMER_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2_key       (ps2_key),
    .hack_scancode (hack_scancode),
    .key_event     (key_event)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic send(input logic p, input logic e, input logic [7:0] code);
    @(posedge clk);
    #1;
    ps2_key = {~ps2_key[10], p, e, code};
    last_ev = cyc;
  endtask

  task automatic expect_val(input int dly, input int v);
    exp_cyc.push_back(last_ev + dly);
    exp_val.push_back(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    int c;
    int v;
    if (reset || !mon_en) begin
      last_seen = hack_scancode;
    end else begin
      checks++;
      if (key_event) begin
        if (exp_cyc.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got=%0d want=no_event", cyc, hack_scancode);
        end else begin
          c = exp_cyc.pop_front();
          v = exp_val.pop_front();
          if (c != cyc || v != int'(hack_scancode)) begin
            errors++;
            $display("FAIL event cyc=%0d got=%0d want_cyc=%0d want=%0d", cyc, hack_scancode, c, v);
          end
        end
      end else if (hack_scancode != last_seen) begin
        errors++;
        $display("FAIL silent_change cyc=%0d got=%0d want=%0d", cyc, hack_scancode, last_seen);
      end
      last_seen = hack_scancode;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    ps2_key = 11'h400;
    idle(3);
    check("reset_scancode", int'(hack_scancode), 0);
    check("reset_event", int'(key_event), 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(10);
    check("arm_idle_high", int'(hack_scancode), 0);

    send(1'b1, 1'b0, 8'h1C); expect_val(2, 65);
    idle(4);
    send(1'b0, 1'b0, 8'h1C); expect_val(2, 0);
    idle(4);

    send(1'b1, 1'b1, 8'h75); expect_val(2, 131);
    send(1'b1, 1'b0, 8'h75);
    send(1'b0, 1'b0, 8'h75);
    send(1'b0, 1'b1, 8'h75); expect_val(2, 0);
    idle(4);

    send(1'b1, 1'b0, 8'h5A); expect_val(2, 128);
    send(1'b1, 1'b0, 8'h66); expect_val(2, 129);
    send(1'b0, 1'b0, 8'h5A);
    send(1'b0, 1'b0, 8'h66); expect_val(2, 0);
    idle(4);

    send(1'b1, 1'b0, 8'h12);
    send(1'b1, 1'b0, 8'h16); expect_val(2, SHIFT_ONE);
    send(1'b0, 1'b0, 8'h12);
    send(1'b0, 1'b0, 8'h16); expect_val(2, 0);
    idle(4);

    for (int i = 0; i < 9; i++) begin
      send(1'b1, tk[i][8], tk[i][7:0]); expect_val(2, tv[i]);
      idle(2);
      send(1'b0, tk[i][8], tk[i][7:0]); expect_val(2, 0);
      idle(2);
    end

    // re-press of the held key and a stray release must stay silent
    send(1'b1, 1'b0, 8'h4B); expect_val(2, 76);
    idle(2);
    send(1'b1, 1'b0, 8'h4B);
    idle(2);
    send(1'b0, 1'b0, 8'h4B); expect_val(2, 0);
    send(1'b0, 1'b0, 8'h1A);
    idle(4);

    send(1'b1, 1'b0, 8'h1C);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(4);
    check("reset_mid_event", int'(hack_scancode), 0);
    send(1'b1, 1'b0, 8'h1C); expect_val(2, 65);
    idle(2);
    send(1'b0, 1'b0, 8'h1C); expect_val(2, 0);
    idle(4);

    send(1'b1, 1'b0, 8'h29); expect_val(2, 32); expect_val(100, 0);
    for (int n = 0; n < 300 && exp_cyc.size() != 0; n++) idle(1);
    idle(4);
    check("scoreboard_drained", exp_cyc.size(), 0);
    check("final_scancode", int'(hack_scancode), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
